// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants and helpers for the shared data-memory arbiter
//
// Purpose: default parameter values, counter limit and a constant clog2 helper
//          used by shared_dmem_arb and rr_arbiter.
// Ports:   none (package).
package dmem_arb_pkg;

    localparam int DEF_NUM_CORES = 2;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DEPTH     = 64;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first requesting core at or after the pointer, searching
//          upward and wrapping to 0.
// Ports:   req     - per-core request vector
//          ptr     - current round-robin start index (always < NUM_CORES)
//          gnt     - one-hot grant, all zero when no request
//          gnt_idx - binary index of the granted core (0 when no grant)
module rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int IDX_W     = clog2(DEF_NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_CORES-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // ptr and the offset are both below NUM_CORES, so one conditional
    // subtraction is enough to wrap the candidate index.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int off = 0; off < NUM_CORES; off++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(NUM_CORES)) begin
                sum = sum - (IDX_W+1)'(NUM_CORES);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/shared_dmem_arb.sv
// rtl/shared_dmem_arb.sv - multi-core round-robin access to a single-port data memory
//
// Purpose: arbitrates NUM_CORES requesters onto one DEPTH x DATA_W word array,
//          one access per cycle, with registered per-core read responses and a
//          saturating count of contended cycles.
// Ports:   clk          - clock, all state on rising edge
//          reset        - asynchronous active-low reset
//          req/we       - per-core request and write enable
//          addr/wdata   - flattened per-core byte address and write data
//          gnt          - one-hot combinational grant
//          rvalid/rdata - per-core read response, one cycle after grant
//          conflict_cnt - saturating count of cycles with more than one request
module shared_dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [NUM_CORES*DATA_W-1:0] rdata,
    output logic [15:0]                 conflict_cnt
);

    localparam int IDX_W  = clog2(NUM_CORES);
    localparam int WORD_W = clog2(DEPTH);

    // Memory is intentionally not reset; contents survive a reset pulse.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]            ptr_q, ptr_d;
    logic [NUM_CORES-1:0]        rvalid_q, rvalid_d;
    logic [NUM_CORES*DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0]                 cnt_q, cnt_d;

    logic [NUM_CORES-1:0] arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 access;
    logic                 sel_we;
    logic [WORD_W-1:0]    word_idx;
    logic [DATA_W-1:0]    sel_wdata;
    int                   n_req;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Gating the grant with reset blocks both writes and read responses while
    // reset is held, without waiting for a clock edge.
    assign gnt    = reset ? arb_gnt : '0;
    assign access = |gnt;
    assign sel_we = we[arb_idx];
    // Only addr bits [WORD_W+1:2] of the granted core select the word; the
    // rest of the address wraps modulo DEPTH words.
    assign word_idx  = addr[arb_idx*ADDR_W+2 +: WORD_W];
    assign sel_wdata = wdata[arb_idx*DATA_W +: DATA_W];

    always_comb begin
        ptr_d    = ptr_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        n_req    = 0;

        if (access) begin
            ptr_d = (arb_idx == IDX_W'(NUM_CORES-1)) ? '0 : arb_idx + 1'b1;
            if (!sel_we) begin
                rvalid_d[arb_idx]                   = 1'b1;
                rdata_d[arb_idx*DATA_W +: DATA_W]   = mem[word_idx];
            end
        end

        for (int i = 0; i < NUM_CORES; i++) begin
            if (req[i]) begin
                n_req = n_req + 1;
            end
        end
        if (n_req > 1 && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (access && sel_we) begin
            mem[word_idx] <= sel_wdata;
        end
    end

    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_shared_dmem_arb.sv
// tb/tb_shared_dmem_arb.sv - directed self-checking bench for shared_dmem_arb
module tb_shared_dmem_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Two-core instance (default parameters)
    logic [1:0]   req_a, we_a, gnt_a, rvalid_a;
    logic [63:0]  addr_a, wdata_a, rdata_a;
    logic [15:0]  cnt_a;

    // Four-core instance
    logic [3:0]   req_b, we_b, gnt_b, rvalid_b;
    logic [127:0] addr_b, wdata_b, rdata_b;
    logic [15:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    shared_dmem_arb dut_a (
        .clk          (clk),
        .reset        (reset),
        .req          (req_a),
        .we           (we_a),
        .addr         (addr_a),
        .wdata        (wdata_a),
        .gnt          (gnt_a),
        .rvalid       (rvalid_a),
        .rdata        (rdata_a),
        .conflict_cnt (cnt_a)
    );

    shared_dmem_arb #(.NUM_CORES(4)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .req          (req_b),
        .we           (we_b),
        .addr         (addr_b),
        .wdata        (wdata_b),
        .gnt          (gnt_b),
        .rvalid       (rvalid_b),
        .rdata        (rdata_b),
        .conflict_cnt (cnt_b)
    );

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_a = 2'b11;
        @(negedge clk);
        #1;
        total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b expected 00", gnt_a); end
        total++; if (rvalid_a !== 2'b00) begin bad++; $display("FAIL reset_rvalid: got %b expected 00", rvalid_a); end
        total++; if (rdata_a !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", rdata_a); end
        @(negedge clk);
        #1;
        total++; if (cnt_a !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h expected 0", cnt_a); end
        total++; if (gnt_b !== 4'b0000) begin bad++; $display("FAIL reset_gnt_b: got %b expected 0000", gnt_b); end
        @(negedge clk);
        reset = 1'b1;
        req_a = 2'b00;
        #1;
        total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL idle_gnt: got %b expected 00", gnt_a); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req_a = 2'b01; we_a = 2'b01;
        addr_a[31:0] = 32'h10; wdata_a[31:0] = 32'hDEADBEEF;
        #1;
        total++; if (gnt_a !== 2'b01) begin bad++; $display("FAIL wr_gnt: got %b expected 01", gnt_a); end
        @(posedge clk);
        #1;
        total++; if (rvalid_a !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid: got %b expected 00", rvalid_a); end
        @(negedge clk);
        we_a = 2'b00;
        #1;
        total++; if (gnt_a !== 2'b01) begin bad++; $display("FAIL rd_gnt: got %b expected 01", gnt_a); end
        @(posedge clk);
        #1;
        total++; if (rvalid_a !== 2'b01) begin bad++; $display("FAIL rd_rvalid: got %b expected 01", rvalid_a); end
        total++; if (rdata_a[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h expected deadbeef", rdata_a[31:0]); end
        @(negedge clk);
        req_a = 2'b00;
        @(posedge clk);
        #1;
        total++; if (rvalid_a !== 2'b00) begin bad++; $display("FAIL rd_rvalid_drop: got %b expected 00", rvalid_a); end
        total++; if (cnt_a !== 16'h0) begin bad++; $display("FAIL wr_cnt: got %h expected 0", cnt_a); end
    endtask

    task automatic test_conflict();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_a = 2'b11; we_a = 2'b00;
            addr_a = {32'h10, 32'h10};
            #1;
            total++; if (gnt_a !== exp_g[k]) begin bad++; $display("FAIL rr2_gnt[%0d]: got %b expected %b", k, gnt_a, exp_g[k]); end
            @(posedge clk);
            #1;
            total++; if (rvalid_a !== exp_g[k]) begin bad++; $display("FAIL rr2_rvalid[%0d]: got %b expected %b", k, rvalid_a, exp_g[k]); end
        end
        total++; if (rdata_a !== {32'hDEADBEEF, 32'hDEADBEEF}) begin bad++; $display("FAIL rr2_rdata: got %h expected both deadbeef", rdata_a); end
        total++; if (cnt_a !== 16'd4) begin bad++; $display("FAIL rr2_cnt: got %0d expected 4", cnt_a); end
        @(negedge clk);
        req_a = 2'b00;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        req_a = 2'b01; we_a = 2'b01;
        addr_a[31:0] = 32'h100; wdata_a[31:0] = 32'h5A;
        @(negedge clk);
        we_a = 2'b00; addr_a[31:0] = 32'h0;
        @(posedge clk);
        #1;
        total++; if (rvalid_a !== 2'b01) begin bad++; $display("FAIL wrap_rvalid0: got %b expected 01", rvalid_a); end
        total++; if (rdata_a[31:0] !== 32'h5A) begin bad++; $display("FAIL wrap_rdata0: got %h expected 5a", rdata_a[31:0]); end
        @(negedge clk);
        req_a = 2'b10; we_a = 2'b10;
        addr_a[63:32] = 32'h1FC; wdata_a[63:32] = 32'hA5A50001;
        #1;
        total++; if (gnt_a !== 2'b10) begin bad++; $display("FAIL wrap_gnt1: got %b expected 10", gnt_a); end
        @(negedge clk);
        we_a = 2'b00; addr_a[63:32] = 32'hFC;
        @(posedge clk);
        #1;
        total++; if (rvalid_a !== 2'b10) begin bad++; $display("FAIL wrap_rvalid1: got %b expected 10", rvalid_a); end
        total++; if (rdata_a !== {32'hA5A50001, 32'h0000005A}) begin bad++; $display("FAIL wrap_rdata1: got %h expected a5a500010000005a", rdata_a); end
        @(negedge clk);
        req_a = 2'b00;
        #1;
        total++; if (cnt_a !== 16'd4) begin bad++; $display("FAIL wrap_cnt: got %0d expected 4", cnt_a); end
    endtask

    task automatic test_rr4();
        logic [3:0] exp_g [3];
        exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_b = 4'b1010; we_b = 4'b0000; addr_b = '0;
            #1;
            total++; if (gnt_b !== exp_g[k]) begin bad++; $display("FAIL rr4_gnt[%0d]: got %b expected %b", k, gnt_b, exp_g[k]); end
            @(posedge clk);
            #1;
            total++; if (rvalid_b !== exp_g[k]) begin bad++; $display("FAIL rr4_rvalid[%0d]: got %b expected %b", k, rvalid_b, exp_g[k]); end
        end
        total++; if (cnt_b !== 16'd3) begin bad++; $display("FAIL rr4_cnt: got %0d expected 3", cnt_b); end
        @(negedge clk);
        req_b = 4'b0000;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_a = 2'b01; we_a = 2'b00; addr_a[31:0] = 32'h10;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_a = 2'b00;
        #1;
        total++; if (rvalid_a !== 2'b00) begin bad++; $display("FAIL mid_rvalid: got %b expected 00", rvalid_a); end
        total++; if (cnt_a !== 16'h0) begin bad++; $display("FAIL mid_cnt: got %h expected 0", cnt_a); end
        total++; if (rdata_a !== 64'h0) begin bad++; $display("FAIL mid_rdata: got %h expected 0", rdata_a); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (rvalid_a !== 2'b00) begin bad++; $display("FAIL mid_rvalid_after: got %b expected 00", rvalid_a); end
        @(negedge clk);
        req_a = 2'b01; addr_a[31:0] = 32'h10;
        @(posedge clk);
        #1;
        total++; if (rvalid_a !== 2'b01) begin bad++; $display("FAIL mid_reread_valid: got %b expected 01", rvalid_a); end
        total++; if (rdata_a[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL mid_reread_data: got %h expected deadbeef", rdata_a[31:0]); end
        @(negedge clk);
        addr_a[31:0] = 32'h0;
        @(posedge clk);
        #1;
        total++; if (rdata_a[31:0] !== 32'h5A) begin bad++; $display("FAIL mid_reread_word0: got %h expected 5a", rdata_a[31:0]); end
        @(negedge clk);
        req_a = 2'b00;
    endtask

    task automatic test_saturate();
        pulse_reset();
        @(negedge clk);
        req_a = 2'b11; we_a = 2'b00;
        repeat (65534) @(posedge clk);
        #1;
        total++; if (cnt_a !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe: got %h expected fffe", cnt_a); end
        @(posedge clk);
        #1;
        total++; if (cnt_a !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff: got %h expected ffff", cnt_a); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (cnt_a !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h expected ffff", cnt_a); end
        total++; if (!$onehot(gnt_a)) begin bad++; $display("FAIL sat_gnt_onehot: got %b expected one-hot", gnt_a); end
        @(negedge clk);
        req_a = 2'b00;
    endtask

    initial begin
        reset   = 1'b0;
        req_a   = '0; we_a = '0; addr_a = '0; wdata_a = '0;
        req_b   = '0; we_b = '0; addr_b = '0; wdata_b = '0;
        test_reset();
        test_write_read();
        test_conflict();
        test_wrap();
        test_rr4();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
